// File: rtl/log_range_reducer_if.sv
// Operand/result bus between the raw-operand source, the range reducer and the log core.
// The slave modport is the reducer side; the master modport is the operand source / core side.
interface log_range_reducer_if #(
    parameter int IN_W   = 16,
    parameter int FRAC_W = 10,
    parameter int OUT_W  = 14,
    parameter int EXP_W  = 4
);
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] x0;
    logic [EXP_W-1:0] exp;
    logic             start;
    logic             busy;
    logic             err;

    modport master (
        output in_data, in_valid,
        input  in_ready, x0, exp, start, busy, err
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, x0, exp, start, busy, err
    );
endinterface

// File: rtl/log_range_reducer.sv
// Normalises a raw unsigned operand to a 4.FRAC_W mantissa in [1,2) plus exponent for the log core.
// Build macro LOG_RR_ROUND_EN: round-half-up the mantissa instead of truncating.
module log_range_reducer #(
    parameter int IN_W   = 16,
    parameter int FRAC_W = 10,
    parameter int OUT_W  = 14,
    parameter int EXP_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    log_range_reducer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, EMIT} state_t;

    localparam logic [EXP_W-1:0] CNT_TOP = EXP_W'(IN_W - 1);

    state_t           state, state_n;
    logic [IN_W-1:0]  shreg, shreg_n;
    logic [EXP_W-1:0] cnt, cnt_n;
    logic [EXP_W-1:0] exp_q, exp_n, mant_e;
    logic [OUT_W-1:0] x0_q, x0_n;
    logic             err_q, err_n;
    logic [FRAC_W:0]  mant_t, mant_x;

    assign mant_t = shreg[IN_W-1 -: FRAC_W+1];

`ifdef LOG_RR_ROUND_EN
    // Round bit sits just below the kept field; absent when the operand is too narrow.
    localparam int RIDX = IN_W - 2 - FRAC_W;
    localparam int RSEL = (RIDX >= 0) ? RIDX : 0;

    logic              rbit;
    logic [FRAC_W+1:0] mant_r;

    assign rbit   = (RIDX >= 0) ? shreg[RSEL] : 1'b0;
    assign mant_r = {1'b0, mant_t} + {{(FRAC_W+1){1'b0}}, rbit};

    always_comb begin
        mant_x = mant_r[FRAC_W:0];
        mant_e = cnt;
        if (mant_r[FRAC_W+1]) begin
            if (cnt == CNT_TOP) begin
                mant_x = '1;
            end else begin
                mant_x = {1'b1, {FRAC_W{1'b0}}};
                mant_e = cnt + EXP_W'(1);
            end
        end
    end
`else
    assign mant_x = mant_t;
    assign mant_e = cnt;
`endif

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        x0_n    = x0_q;
        exp_n   = exp_q;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    shreg_n = bus.in_data;
                    cnt_n   = CNT_TOP;
                    if (bus.in_data == '0) begin
                        err_n = 1'b1;
                    end else begin
                        state_n = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (shreg[IN_W-1]) begin
                    x0_n    = {{(OUT_W-FRAC_W-1){1'b0}}, mant_x};
                    exp_n   = mant_e;
                    state_n = EMIT;
                end else begin
                    shreg_n = shreg << 1;
                    cnt_n   = cnt - EXP_W'(1);
                end
            end
            EMIT:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
            cnt   <= '0;
            x0_q  <= '0;
            exp_q <= '0;
            err_q <= 1'b0;
        end else begin
            shreg <= shreg_n;
            cnt   <= cnt_n;
            x0_q  <= x0_n;
            exp_q <= exp_n;
            err_q <= err_n;
        end
    end

    assign bus.in_ready = (state == IDLE);
    assign bus.busy     = (state != IDLE);
    assign bus.start    = (state == EMIT);
    assign bus.x0       = x0_q;
    assign bus.exp      = exp_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_log_range_reducer.sv
// Bench for log_range_reducer: timeline reference model plus directed literal cases and random traffic.
// Honours LOG_RR_ROUND_EN the same way the design does.
module tb_log_range_reducer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model state: edge counter and the cycles at which events are due.
    int          cyc         = 0;
    int          m_busy_end  = -10;
    int          m_start_cyc = -10;
    int          m_err_cyc   = -10;
    int          m_accepts   = 0;
    int          m_lz        = 0;
    logic        m_idle      = 1'b1;
    logic [13:0] m_x0 = '0, p_x0 = '0;
    logic [3:0]  m_exp = '0, p_exp = '0;
    logic        c_busy;

    always #5 clk = ~clk;

    log_range_reducer_if #(.IN_W(16), .FRAC_W(10), .OUT_W(14), .EXP_W(4)) bus ();

    log_range_reducer #(.IN_W(16), .FRAC_W(10), .OUT_W(14), .EXP_W(4)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Normalisation from first principles: locate the leading one, scale, keep 11 bits.
    function automatic void ref_op(input logic [15:0] v, output int lz,
                                   output logic [13:0] x, output logic [3:0] e);
        int          msb;
        int unsigned norm, mant;
        msb = 15;
        while (msb > 0 && v[msb] == 1'b0) msb--;
        lz   = 15 - msb;
        norm = 32'(v) << lz;
        mant = norm >> 5;
`ifdef LOG_RR_ROUND_EN
        mant = mant + ((norm >> 4) & 1);
        if (mant == 2048) begin
            if (msb == 15) begin
                mant = 2047;
            end else begin
                mant = 1024;
                msb  = msb + 1;
            end
        end
`endif
        x = 14'(mant);
        e = 4'(msb);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy_end  = -10;
            m_start_cyc = -10;
            m_err_cyc   = -10;
            m_x0        = '0;
            m_exp       = '0;
        end else begin
            m_idle = (cyc > m_busy_end);
            cyc    = cyc + 1;
            if (cyc == m_start_cyc) begin
                m_x0  = p_x0;
                m_exp = p_exp;
            end
            if (m_idle && bus.in_valid) begin
                m_accepts++;
                if (bus.in_data == 16'h0000) begin
                    m_err_cyc = cyc;
                end else begin
                    ref_op(bus.in_data, m_lz, p_x0, p_exp);
                    m_busy_end  = cyc + m_lz + 1;
                    m_start_cyc = m_busy_end;
                end
            end
        end
    end

    always @(negedge clk) begin
        c_busy = (cyc <= m_busy_end);
        chk("in_ready", 32'(bus.in_ready), 32'(!c_busy));
        chk("busy",     32'(bus.busy),     32'(c_busy));
        chk("start",    32'(bus.start),    32'(cyc == m_start_cyc));
        chk("err",      32'(bus.err),      32'(cyc == m_err_cyc));
        chk("x0",       32'(bus.x0),       32'(m_x0));
        chk("exp",      32'(bus.exp),      32'(m_exp));
    end

    task automatic accept_op(input logic [15:0] v, output int a);
        int n0, k;
        @(negedge clk);
        bus.in_data  = v;
        bus.in_valid = 1'b1;
        n0 = m_accepts;
        k  = 0;
        while (m_accepts == n0 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        bus.in_valid = 1'b0;
        chk("accept", 32'(m_accepts - n0), 32'd1);
        a = cyc;
    endtask

    task automatic directed(input logic [15:0] v, input logic [13:0] rx0, input int rexp, input int rlat);
        int a, k;
        accept_op(v, a);
        k = 0;
        while (bus.start !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("lat",       32'(cyc - a + 1), 32'(rlat));
        chk("lit_x0",    32'(bus.x0),      32'(rx0));
        chk("lit_exp",   32'(bus.exp),     32'(rexp));
        chk("model_x0",  32'(m_x0),        32'(rx0));
        chk("model_exp", 32'(m_exp),       32'(rexp));
    endtask

    initial begin
        int          a, nstart;
        logic [15:0] r;
        int          sh;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_x0",    32'(bus.x0),       32'h0);
        chk("rst_exp",   32'(bus.exp),      32'h0);
        chk("rst_start", 32'(bus.start),    32'h0);
        chk("rst_busy",  32'(bus.busy),     32'h0);
        chk("rst_err",   32'(bus.err),      32'h0);
        chk("rst_ready", 32'(bus.in_ready), 32'h1);

        directed(16'h8000, 14'h0400, 15, 2);
        directed(16'h0001, 14'h0400, 0, 17);
        directed(16'h0017, 14'h05C0, 4, 13);
`ifdef LOG_RR_ROUND_EN
        directed(16'h0FFF, 14'h0400, 12, 6);
`else
        directed(16'h0FFF, 14'h07FF, 11, 6);
`endif
        directed(16'hFFFF, 14'h07FF, 15, 2);

        // Zero operand: error pulse only, stage stays ready.
        accept_op(16'h0000, a);
        @(negedge clk);
        chk("zero_err",   32'(bus.err),      32'h1);
        chk("zero_ready", 32'(bus.in_ready), 32'h1);
        nstart = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.start === 1'b1) nstart++;
        end
        chk("zero_nostart", 32'(nstart), 32'h0);

        // Reset in the middle of a long shift aborts it immediately.
        accept_op(16'h0001, a);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_x0",    32'(bus.x0),       32'h0);
        chk("abort_exp",   32'(bus.exp),      32'h0);
        chk("abort_start", 32'(bus.start),    32'h0);
        chk("abort_busy",  32'(bus.busy),     32'h0);
        chk("abort_ready", 32'(bus.in_ready), 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rel_ready", 32'(bus.in_ready), 32'h1);
        directed(16'h0017, 14'h05C0, 4, 13);

        // Random traffic, including offers while busy that must be ignored.
        repeat (3000) begin
            @(negedge clk);
            r  = 16'($urandom);
            sh = $urandom_range(0, 16);
            bus.in_data  = r >> sh;
            bus.in_valid = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (30) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
